spm_bus_slave: RTL

- Bus-side responder for the 4096x32 dual-port scratch-pad RAM.
- Accepts single-word read/write transactions from the processor bus and drives one RAM port: address, write enable, write data, and registered read data.
- Implements per-byte writes by read-modify-write, because the RAM has only a single word-wide write enable.
- Sits between the bus interconnect and port B of the scratch-pad RAM.

---
 rtl/spm_bus_slave_if.sv | 25 ++
 rtl/spm_bus_slave.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spm_bus_slave_if.sv
// Processor-bus side of the scratch-pad RAM responder.
// Active-low strobe/ready handshake for single-word transfers.
interface spm_bus_slave_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              as_;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        byte_en;
    logic [DATA_W-1:0] rd_data;
    logic              rdy_;
    logic              busy;

    modport master (
        output as_, rw, addr, wr_data, byte_en,
        input  rd_data, rdy_, busy
    );

    modport slave (
        input  as_, rw, addr, wr_data, byte_en,
        output rd_data, rdy_, busy
    );
endinterface

// File: rtl/spm_bus_slave.sv
// Bus responder driving port B of the 4096x32 scratch-pad RAM.
// Byte-lane writes are done as read-modify-write since the RAM has one word write enable.
module spm_bus_slave #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    spm_bus_slave_if.slave    bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wd,
    input  logic [DATA_W-1:0] ram_rd
);
    localparam int LANES = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_RD_DATA  = 3'd2,
        S_RMW_WAIT = 3'd3,
        S_RMW_WR   = 3'd4,
        S_WR       = 3'd5,
        S_ACK      = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rmw_phase;
    logic              w_rmw_phase_nxt;
    logic [3:0]        r_byte_en;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rdy_n;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wd;

    logic [3:0]        w_byte_en_nxt;
    logic [DATA_W-1:0] w_wr_data_nxt;
    logic [DATA_W-1:0] w_rd_data_nxt;
    logic              w_rdy_n_nxt;
    logic [ADDR_W-1:0] w_ram_addr_nxt;
    logic              w_ram_we_nxt;
    logic [DATA_W-1:0] w_ram_wd_nxt;

    function automatic logic [DATA_W-1:0] f_merge(
        input logic [3:0]        be,
        input logic [DATA_W-1:0] wd,
        input logic [DATA_W-1:0] rd
    );
        logic [DATA_W-1:0] m;
        m = rd;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) begin
                m[8*i +: 8] = wd[8*i +: 8];
            end else begin
                m[8*i +: 8] = rd[8*i +: 8];
            end
        end
        return m;
    endfunction

    // State register; RMW_WAIT spans two cycles so ram_rd is valid before the merge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rmw_phase <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rmw_phase <= w_rmw_phase_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_rmw_phase_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.as_) begin
                    if (bus.rw) begin
                        w_state_nxt = S_RD_WAIT;
                    end else if (bus.byte_en == 4'hF) begin
                        w_state_nxt = S_WR;
                    end else if (bus.byte_en == 4'h0) begin
                        w_state_nxt = S_ACK;
                    end else begin
                        w_state_nxt = S_RMW_WAIT;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_WAIT: w_state_nxt = S_RD_DATA;
            S_RD_DATA: w_state_nxt = S_ACK;
            S_WR:      w_state_nxt = S_ACK;
            S_RMW_WAIT: begin
                if (r_rmw_phase) begin
                    w_state_nxt = S_RMW_WR;
                end else begin
                    w_rmw_phase_nxt = 1'b1;
                end
            end
            S_RMW_WR:  w_state_nxt = S_ACK;
            // A null write enters ACK with rdy_ still high and pulses it on the next edge.
            S_ACK: begin
                if (!r_rdy_n) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ACK;
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and captured request.
    always_comb begin
        w_byte_en_nxt  = r_byte_en;
        w_wr_data_nxt  = r_wr_data;
        w_rd_data_nxt  = r_rd_data;
        w_rdy_n_nxt    = 1'b1;
        w_ram_addr_nxt = r_ram_addr;
        w_ram_we_nxt   = 1'b0;
        w_ram_wd_nxt   = r_ram_wd;
        case (r_state)
            S_IDLE: begin
                if (!bus.as_) begin
                    w_byte_en_nxt  = bus.byte_en;
                    w_wr_data_nxt  = bus.wr_data;
                    w_ram_addr_nxt = bus.addr;
                    if (!bus.rw && (bus.byte_en == 4'hF)) begin
                        w_ram_we_nxt = 1'b1;
                        w_ram_wd_nxt = bus.wr_data;
                    end else begin
                        w_ram_we_nxt = 1'b0;
                    end
                end else begin
                    w_ram_we_nxt = 1'b0;
                end
            end
            S_RD_DATA: begin
                w_rd_data_nxt = ram_rd;
                w_rdy_n_nxt   = 1'b0;
            end
            S_WR:       w_rdy_n_nxt = 1'b0;
            S_RMW_WAIT: begin
                if (r_rmw_phase) begin
                    w_ram_wd_nxt = f_merge(r_byte_en, r_wr_data, ram_rd);
                    w_ram_we_nxt = 1'b1;
                end else begin
                    w_ram_we_nxt = 1'b0;
                end
            end
            S_RMW_WR:   w_rdy_n_nxt = 1'b0;
            S_ACK: begin
                if (r_rdy_n) begin
                    w_rdy_n_nxt = 1'b0;
                end else begin
                    w_rdy_n_nxt = 1'b1;
                end
            end
            default:    w_rdy_n_nxt = 1'b1;
        endcase
    end

    // Output and capture registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_en  <= 4'h0;
            r_wr_data  <= {DATA_W{1'b0}};
            r_rd_data  <= {DATA_W{1'b0}};
            r_rdy_n    <= 1'b1;
            r_ram_addr <= {ADDR_W{1'b0}};
            r_ram_we   <= 1'b0;
            r_ram_wd   <= {DATA_W{1'b0}};
        end else begin
            r_byte_en  <= w_byte_en_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rdy_n    <= w_rdy_n_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_we   <= w_ram_we_nxt;
            r_ram_wd   <= w_ram_wd_nxt;
        end
    end

    assign bus.rd_data = r_rd_data;
    assign bus.rdy_    = r_rdy_n;
    assign bus.busy    = (r_state != S_IDLE);
    assign ram_addr    = r_ram_addr;
    assign ram_we      = r_ram_we;
    assign ram_wd      = r_ram_wd;
endmodule
